multi_fx_engine: RTL and testbench

MULTI_FX_ENGINE -- requirements
Module: multi_fx_engine

---
 rtl/fx_pkg.sv | 30 +++
 rtl/fx_fifo.sv | 64 ++++++
 rtl/multi_fx_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_multi_fx_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared constants and types for the multi-channel gain/clip effects engine.
// Holds the register map, STATUS bit positions, engine states and the Q8.8 fraction width.
package fx_pkg;

    localparam logic [4:0] ADDR_STATUS    = 5'd0;
    localparam logic [4:0] ADDR_CTRL      = 5'd1;
    localparam logic [4:0] ADDR_IN        = 5'd2;
    localparam logic [4:0] ADDR_OUT       = 5'd3;
    localparam logic [4:0] ADDR_CLIPCNT   = 5'd4;
    localparam logic [4:0] ADDR_GAIN_BASE = 5'd8;

    localparam int ST_IN_EMPTY  = 0;
    localparam int ST_IN_FULL   = 1;
    localparam int ST_OUT_EMPTY = 2;
    localparam int ST_OUT_FULL  = 3;
    localparam int ST_OVERFLOW  = 4;
    localparam int ST_UNDERFLOW = 5;

    localparam int Q_FRAC = 8;
    localparam int MAX_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_SAT   = 2'd2,
        S_WRITE = 2'd3
    } fx_state_t;

endpackage

// File: rtl/fx_fifo.sv
// Synchronous FIFO of {channel tag, sample} entries with a registered head output.
// q always holds the current head entry and is meaningful only while empty is low.
module fx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                clk500,
    input  logic                reset,
    input  logic                push,
    input  logic [DATA_W+2:0]   wdata,
    input  logic                pop,
    output logic [DATA_W+2:0]   q,
    output logic                full,
    output logic                empty
);

    localparam int E_W = DATA_W + 3;
    localparam int A_W = $clog2(DEPTH);

    logic [E_W-1:0] mem [DEPTH];
    logic [A_W-1:0] wr_ptr;
    logic [A_W-1:0] rd_ptr;
    logic [A_W-1:0] rd_ptr_nxt;
    logic [A_W:0]   count;
    logic           push_ok;
    logic           pop_ok;

    assign full       = (count == (A_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign rd_ptr_nxt = pop_ok ? A_W'(rd_ptr + 1'b1) : rd_ptr;

    always_ff @(posedge clk500) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    // A push landing in the slot that becomes the head is forwarded straight to q.
    always_ff @(posedge clk500) begin
        if (push_ok && (wr_ptr == rd_ptr_nxt))
            q <= wdata;
        else
            q <= mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk500) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= A_W'(wr_ptr + 1'b1);
            rd_ptr <= rd_ptr_nxt;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_fx_engine.sv
// Interleaved multi-channel gain + symmetric clip engine behind an Avalon-MM slave.
// Optional macro FX_CLIP_COUNT_EN builds the saturating CLIPCNT counter.
module multi_fx_engine
    import fx_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic        clk500,
    input  logic        reset,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int P_W = DATA_W + 17;
    localparam logic [MAX_CH-1:0] CH_MASK = MAX_CH'((1 << CHANNELS) - 1);

    function automatic logic [DATA_W:0] sat_clamp(input logic signed [P_W-1:0] p,
                                                  input logic [DATA_W-2:0] lim);
        logic signed [P_W-1:0] s;
        logic signed [P_W-1:0] hi;
        logic signed [P_W-1:0] lo;
        s  = p >>> Q_FRAC;
        hi = P_W'($signed({1'b0, lim}));
        lo = -hi;
        if (s > hi)
            return {1'b1, hi[DATA_W-1:0]};
        else if (s < lo)
            return {1'b1, lo[DATA_W-1:0]};
        else
            return {1'b0, s[DATA_W-1:0]};
    endfunction

    fx_state_t state, state_nxt;

    logic [15:0]       gain_r  [MAX_CH];
    logic [DATA_W-2:0] boost_r [MAX_CH];
    logic [MAX_CH-1:0] ctrl_r;
    logic [CH_W-1:0]   in_ch;
    logic              ovf_r;
    logic              udf_r;
    logic [31:0]       clip_cnt;
    logic [31:0]       rd_mux;
    logic [31:0]       status_w;

    logic [DATA_W+2:0] in_q, out_q;
    logic              in_full, in_empty, out_full, out_empty;
    logic              in_push, out_pop, eng_pop, eng_push;

    logic [4:0]        reg_off;
    logic [CH_W-1:0]   reg_ch;
    logic              reg_hit;

    logic signed [DATA_W-1:0] x_p0, x_p1, y_p2;
    logic [CH_W-1:0]          ch_p0, ch_p1, ch_p2;
    logic signed [P_W-1:0]    p_p1;
    logic [DATA_W-2:0]        boost_p1;
    logic                     byp_p1;
    logic                     clip_p2;
    logic                     vld_p0, vld_p1, vld_p2;

    assign in_push = avs_write && (avs_address == ADDR_IN);
    assign out_pop = avs_read && (avs_address == ADDR_OUT);
    assign reg_off = avs_address - ADDR_GAIN_BASE;
    assign reg_ch  = reg_off[3:1];
    assign reg_hit = (avs_address >= ADDR_GAIN_BASE) && !reg_off[4] && (int'(reg_ch) < CHANNELS);

    fx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk500 (clk500),
        .reset  (reset),
        .push   (in_push),
        .wdata  ({in_ch, avs_writedata[DATA_W-1:0]}),
        .pop    (eng_pop),
        .q      (in_q),
        .full   (in_full),
        .empty  (in_empty)
    );

    fx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk500 (clk500),
        .reset  (reset),
        .push   (eng_push),
        .wdata  ({ch_p2, y_p2}),
        .pop    (out_pop),
        .q      (out_q),
        .full   (out_full),
        .empty  (out_empty)
    );

    always_ff @(posedge clk500) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        eng_pop   = 1'b0;
        eng_push  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!in_empty && !out_full) begin
                    eng_pop   = 1'b1;
                    state_nxt = S_MUL;
                end
            end
            S_MUL:   state_nxt = S_SAT;
            S_SAT:   state_nxt = S_WRITE;
            S_WRITE: begin
                eng_push  = vld_p2;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk500) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= eng_pop;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // p0: capture the popped head entry
    always_ff @(posedge clk500) begin
        if (eng_pop) begin
            x_p0  <= in_q[DATA_W-1:0];
            ch_p0 <= in_q[DATA_W+2:DATA_W];
        end
    end

    // p1: multiply; per-channel settings are snapshotted here for the whole sample
    always_ff @(posedge clk500) begin
        if (vld_p0) begin
            p_p1     <= P_W'(x_p0) * P_W'($signed({1'b0, gain_r[ch_p0]}));
            x_p1     <= x_p0;
            ch_p1    <= ch_p0;
            boost_p1 <= boost_r[ch_p0];
            byp_p1   <= ctrl_r[ch_p0];
        end
    end

    // p2: rescale and clamp, or pass the raw sample through in bypass
    always_ff @(posedge clk500) begin
        if (vld_p1) begin
            {clip_p2, y_p2} <= byp_p1 ? {1'b0, x_p1} : sat_clamp(p_p1, boost_p1);
            ch_p2           <= ch_p1;
        end
    end

    always_ff @(posedge clk500) begin
        if (reset) begin
            ctrl_r <= '0;
            for (int c = 0; c < MAX_CH; c++) begin
                gain_r[c]  <= 16'h0100;
                boost_r[c] <= '1;
            end
        end else if (avs_write) begin
            if (avs_address == ADDR_CTRL)
                ctrl_r <= avs_writedata[MAX_CH-1:0] & CH_MASK;
            else if (reg_hit) begin
                if (reg_off[0])
                    boost_r[reg_ch] <= avs_writedata[DATA_W-2:0];
                else
                    gain_r[reg_ch] <= avs_writedata[15:0];
            end
        end
    end

    // A dropped IN write leaves the channel sequence where it was.
    always_ff @(posedge clk500) begin
        if (reset)
            in_ch <= '0;
        else if (in_push && !in_full)
            in_ch <= (in_ch == CH_W'(CHANNELS - 1)) ? '0 : in_ch + 1'b1;
    end

    always_ff @(posedge clk500) begin
        if (reset) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (in_push && in_full)
                ovf_r <= 1'b1;
            else if (avs_write && (avs_address == ADDR_STATUS) && avs_writedata[ST_OVERFLOW])
                ovf_r <= 1'b0;
            if (out_pop && out_empty)
                udf_r <= 1'b1;
            else if (avs_write && (avs_address == ADDR_STATUS) && avs_writedata[ST_UNDERFLOW])
                udf_r <= 1'b0;
        end
    end

`ifdef FX_CLIP_COUNT_EN
    always_ff @(posedge clk500) begin
        if (reset)
            clip_cnt <= '0;
        else if (vld_p2 && clip_p2 && (clip_cnt != '1))
            clip_cnt <= clip_cnt + 1'b1;
    end
`else
    logic unused_clip;
    assign clip_cnt    = '0;
    assign unused_clip = clip_p2;
`endif

    always_comb begin
        status_w               = '0;
        status_w[ST_IN_EMPTY]  = in_empty;
        status_w[ST_IN_FULL]   = in_full;
        status_w[ST_OUT_EMPTY] = out_empty;
        status_w[ST_OUT_FULL]  = out_full;
        status_w[ST_OVERFLOW]  = ovf_r;
        status_w[ST_UNDERFLOW] = udf_r;
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_STATUS:  rd_mux = status_w;
            ADDR_CTRL:    rd_mux = 32'(ctrl_r);
            ADDR_OUT: begin
                if (!out_empty)
                    rd_mux = {13'b0, out_q[DATA_W+2:DATA_W], 16'($signed(out_q[DATA_W-1:0]))};
            end
            ADDR_CLIPCNT: rd_mux = clip_cnt;
            default: begin
                if (reg_hit)
                    rd_mux = reg_off[0] ? 32'(boost_r[reg_ch]) : 32'(gain_r[reg_ch]);
            end
        endcase
    end

    always_ff @(posedge clk500) begin
        if (reset)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_mux;
    end

    assign irq = ovf_r || udf_r || !out_empty;

    logic unused_ok;
    assign unused_ok = ^avs_writedata[31:16];

endmodule

// File: tb/tb_multi_fx_engine.sv
// Self-checking bench for multi_fx_engine with a queue-based arithmetic reference model.
// Expected CLIPCNT follows FX_CLIP_COUNT_EN the same way the build does.
module tb_multi_fx_engine;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 8;
    localparam int CHANNELS = 2;

    logic        clk500 = 1'b0;
    logic        reset  = 1'b1;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [15:0] gain_m  [CHANNELS];
    logic [14:0] boost_m [CHANNELS];
    logic [1:0]  ctrl_m;
    logic [31:0] exp_q[$];
    int          clip_m;
    int          in_ch_m;

    multi_fx_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
        .clk500        (clk500),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #5 clk500 = ~clk500;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int clip_expected();
`ifdef FX_CLIP_COUNT_EN
        return clip_m;
`else
        return 0;
`endif
    endfunction

    // Reference: y = floor(x * gain / 256) clamped to +/-boost, or x itself in bypass.
    function automatic logic [31:0] model_sample(input int ch, input logic [15:0] xs, output bit clipped);
        longint x, y, b;
        x = longint'($signed(xs));
        b = longint'(boost_m[ch]);
        clipped = 1'b0;
        if (ctrl_m[ch]) begin
            y = x;
        end else begin
            y = (x * longint'(gain_m[ch])) >>> 8;
            if (y > b) begin
                y = b;
                clipped = 1'b1;
            end else if (y < -b) begin
                y = -b;
                clipped = 1'b1;
            end
        end
        return {13'b0, 3'(ch), 16'(y)};
    endfunction

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 4))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk500);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk500);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk500);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk500);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk500);
        d        = avs_readdata;
        avs_read = 1'b0;
    endtask

    task automatic do_reset();
        avs_read  = 1'b0;
        avs_write = 1'b0;
        reset     = 1'b1;
        idle(3);
        reset = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            gain_m[c]  = 16'h0100;
            boost_m[c] = 15'h7FFF;
        end
        ctrl_m  = '0;
        clip_m  = 0;
        in_ch_m = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [15:0] x);
        bit c;
        exp_q.push_back(model_sample(in_ch_m, x, c));
        if (c) clip_m++;
        in_ch_m = (in_ch_m + 1) % CHANNELS;
    endtask

    task automatic set_gain(input int ch, input logic [15:0] g);
        bus_write(5'(8 + 2 * ch), {16'h0, g});
        gain_m[ch] = g;
    endtask

    task automatic set_boost(input int ch, input logic [14:0] b);
        bus_write(5'(9 + 2 * ch), {17'h0, b});
        boost_m[ch] = b;
    endtask

    task automatic set_ctrl(input logic [1:0] c);
        bus_write(5'd1, {30'h0, c});
        ctrl_m = c;
    endtask

    task automatic randomize_regs();
        for (int c = 0; c < CHANNELS; c++) begin
            set_gain(c, 16'($urandom_range(0, 16'h03FF)));
            set_boost(c, 15'($urandom_range(0, 16'h7FFF)));
        end
        set_ctrl(2'($urandom_range(0, 3)));
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        checks++;
        if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b, required 00000000 and 0", avs_readdata, irq);
        end
        bus_read(5'd0, rd);
        checks++;
        if (rd !== 32'h05) begin errors++; $display("FAIL reset_status: got %h required %h", rd, 32'h05); end
        bus_read(5'd4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_clipcnt: got %h required %h", rd, 32'h0); end
        bus_read(5'd8, rd);
        checks++;
        if (rd !== 32'h0100) begin errors++; $display("FAIL reset_gain0: got %h required %h", rd, 32'h0100); end
        bus_read(5'd11, rd);
        checks++;
        if (rd !== 32'h7FFF) begin errors++; $display("FAIL reset_boost1: got %h required %h", rd, 32'h7FFF); end
        bus_read(5'd1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h required %h", rd, 32'h0); end
        bus_write(5'd12, 32'h1234);
        bus_read(5'd12, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_gain2: got %h required %h", rd, 32'h0); end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        do_reset();
        bus_write(5'd2, 32'h0000_0100);
        bus_read(5'd0, rd);
        checks++;
        if (rd[2] !== 1'b1) begin errors++; $display("FAIL early_out_empty: got %b required 1", rd[2]); end
        bus_write(5'd2, 32'h0000_FF00);
        idle(10);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b required 1", irq); end
        bus_read(5'd3, rd);
        checks++;
        if (rd !== 32'h0000_0100) begin errors++; $display("FAIL basic_out0: got %h required %h", rd, 32'h0000_0100); end
        bus_read(5'd3, rd);
        checks++;
        if (rd !== 32'h0001_FF00) begin errors++; $display("FAIL basic_out1: got %h required %h", rd, 32'h0001_FF00); end
    endtask

    task automatic test_clip();
        logic [31:0] rd;
        do_reset();
        set_gain(0, 16'h0200);
        set_boost(0, 15'h3000);
        bus_write(5'd2, 32'h0000_2000);
        model_push(16'h2000);
        idle(8);
        bus_read(5'd3, rd);
        checks++;
        if (rd !== 32'h0000_3000) begin errors++; $display("FAIL clip_out: got %h required %h", rd, 32'h0000_3000); end
        bus_read(5'd4, rd);
        checks++;
        if (rd !== 32'(clip_expected())) begin errors++; $display("FAIL clip_count: got %h required %h", rd, clip_expected()); end
    endtask

    task automatic test_bypass();
        logic [31:0] rd;
        do_reset();
        set_ctrl(2'b01);
        set_gain(0, 16'h0400);
        bus_write(5'd2, 32'h0000_7000);
        idle(8);
        bus_read(5'd3, rd);
        checks++;
        if (rd !== 32'h0000_7000) begin errors++; $display("FAIL bypass_out: got %h required %h", rd, 32'h0000_7000); end
        bus_read(5'd4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL bypass_clipcnt: got %h required %h", rd, 32'h0); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [15:0] x;
        do_reset();
        randomize_regs();
        for (int i = 0; i < 8; i++) begin
            x = rand_sample();
            bus_write(5'd2, {16'h0, x});
            model_push(x);
        end
        idle(40);
        for (int i = 0; i < 9; i++) begin
            x = rand_sample();
            bus_write(5'd2, {16'h0, x});
            if (i < 8) model_push(x);
        end
        bus_read(5'd0, rd);
        checks++;
        if (rd !== 32'h1A) begin errors++; $display("FAIL ovf_status: got %h required %h", rd, 32'h1A); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b required 1", irq); end
        bus_write(5'd0, 32'h10);
        bus_read(5'd0, rd);
        checks++;
        if (rd !== 32'h0A) begin errors++; $display("FAIL ovf_w1c: got %h required %h", rd, 32'h0A); end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e;
            if (i == 8) idle(50);
            bus_read(5'd3, rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL ovf_out%0d: got %h required %h", i, rd, e); end
        end
        bus_read(5'd0, rd);
        checks++;
        if (rd !== 32'h05) begin errors++; $display("FAIL ovf_drained: got %h required %h", rd, 32'h05); end
        bus_read(5'd4, rd);
        checks++;
        if (rd !== 32'(clip_expected())) begin errors++; $display("FAIL ovf_clipcnt: got %h required %h", rd, clip_expected()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [15:0] x;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            randomize_regs();
            for (int i = 0; i < 6; i++) begin
                x = rand_sample();
                bus_write(5'd2, {16'h0, x});
                model_push(x);
            end
            idle(4);
            for (int i = 0; i < 6; i++) begin
                logic [31:0] e;
                bus_read(5'd3, rd);
                e = exp_q.pop_front();
                checks++;
                if (rd !== e) begin errors++; $display("FAIL b2b_r%0d_out%0d: got %h required %h", r, i, rd, e); end
                idle(4);
            end
            bus_read(5'd0, rd);
            checks++;
            if (rd !== 32'h05) begin errors++; $display("FAIL b2b_r%0d_status: got %h required %h", r, rd, 32'h05); end
            bus_read(5'd4, rd);
            checks++;
            if (rd !== 32'(clip_expected())) begin errors++; $display("FAIL b2b_r%0d_clipcnt: got %h required %h", r, rd, clip_expected()); end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] rd;
        do_reset();
        bus_read(5'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL udf_data: got %h required %h", rd, 32'h0); end
        bus_read(5'd0, rd);
        checks++;
        if (rd !== 32'h25) begin errors++; $display("FAIL udf_status: got %h required %h", rd, 32'h25); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL udf_irq: got %b required 1", irq); end
        bus_write(5'd0, 32'h20);
        @(negedge clk500);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL udf_irq_clear: got %b required 0", irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        do_reset();
        set_gain(0, 16'h0300);
        bus_write(5'd2, 32'h0000_1234);
        @(negedge clk500);
        @(negedge clk500);
        reset = 1'b1;
        @(negedge clk500);
        reset = 1'b0;
        do_reset_model();
        bus_read(5'd0, rd);
        checks++;
        if (rd !== 32'h05) begin errors++; $display("FAIL midrst_status: got %h required %h", rd, 32'h05); end
        idle(6);
        bus_read(5'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_out: got %h required %h", rd, 32'h0); end
        bus_read(5'd8, rd);
        checks++;
        if (rd !== 32'h0100) begin errors++; $display("FAIL midrst_gain0: got %h required %h", rd, 32'h0100); end
    endtask

    task automatic do_reset_model();
        for (int c = 0; c < CHANNELS; c++) begin
            gain_m[c]  = 16'h0100;
            boost_m[c] = 15'h7FFF;
        end
        ctrl_m  = '0;
        clip_m  = 0;
        in_ch_m = 0;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_bypass();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
